// File: rtl/note_div_calc.sv
// Purpose: turns left/right tone frequencies plus an octave select into 22-bit note_gen dividers via one shared restoring divider.
// Latency: 53 cycles from the IDLE edge that samples an input change to updated outputs with a one-cycle upd pulse.
// Backpressure: none; input changes during a run are ignored until the next IDLE cycle, which restarts if they differ from the snapshot.
module note_div_calc #(
  parameter int CLK_DIVIDEND = 50000000,
  parameter int DIV_W        = 26,
  parameter int OUT_W        = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      freqL,
  input  logic [31:0]      freqR,
  input  logic [2:0]       octave,
  output logic [OUT_W-1:0] note_div_left,
  output logic [OUT_W-1:0] note_div_right,
  output logic             busy,
  output logic             upd
);

  localparam int CNT_W = $clog2(DIV_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DIV_L = 2'd1;
  localparam logic [1:0] DIV_R = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_DIVIDEND);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_W - 1);

  logic [1:0]       state;
  logic             force_flag;
  logic [31:0]      snap_l;
  logic [31:0]      snap_r;
  logic [2:0]       snap_oct;
  logic [32:0]      divisor;
  logic [32:0]      rem;
  logic [DIV_W-1:0] quo;
  logic [DIV_W-1:0] q_l;
  logic [DIV_W-1:0] q_r;
  logic [CNT_W-1:0] cnt;

  logic             req;
  logic [CNT_W-1:0] bit_idx;
  logic [33:0]      rem_sh;
  logic             ge;
  logic [DIV_W-1:0] q_nx;
  logic [32:0]      eff_l;
  logic [32:0]      eff_r;

  // Octave 1 halves the tone frequency, 3 doubles it (kept at full 33 bits), anything else passes through.
  function automatic logic [32:0] eff_div(input logic [31:0] f, input logic [2:0] o);
    case (o)
      3'd1:    return {2'b00, f[31:1]};
      3'd3:    return {f, 1'b0};
      default: return {1'b0, f};
    endcase
  endfunction

  // Zero divisor or zero quotient means silence (divider 1); oversize quotients clamp to all-ones.
  function automatic logic [OUT_W-1:0] post(input logic [32:0] d, input logic [DIV_W-1:0] q);
    if (d == 33'd0 || q == '0)
      return OUT_W'(1);
    else if (|q[DIV_W-1:OUT_W])
      return '1;
    else
      return q[OUT_W-1:0];
  endfunction

  // Restart request, effective divisors and one restoring-division step.
  always_comb begin
    req     = force_flag || (freqL != snap_l) || (freqR != snap_r) || (octave != snap_oct);
    eff_l   = eff_div(snap_l, snap_oct);
    eff_r   = eff_div(snap_r, snap_oct);
    bit_idx = LAST_CNT - cnt;
    rem_sh  = {rem, DIVIDEND[bit_idx]};
    ge      = rem_sh >= {1'b0, divisor};
    q_nx    = {quo[DIV_W-2:0], ge};
  end

  assign busy = (state != IDLE);

  // Sequencer: snapshot in IDLE, left then right quotient bit-serially, then publish both at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      force_flag     <= 1'b1;
      snap_l         <= '0;
      snap_r         <= '0;
      snap_oct       <= '0;
      divisor        <= '0;
      rem            <= '0;
      quo            <= '0;
      q_l            <= '0;
      q_r            <= '0;
      cnt            <= '0;
      note_div_left  <= OUT_W'(1);
      note_div_right <= OUT_W'(1);
      upd            <= 1'b0;
    end else begin
      upd <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            snap_l     <= freqL;
            snap_r     <= freqR;
            snap_oct   <= octave;
            force_flag <= 1'b0;
            divisor    <= eff_div(freqL, octave);
            rem        <= '0;
            quo        <= '0;
            cnt        <= '0;
            state      <= DIV_L;
          end
        end
        DIV_L, DIV_R: begin
          rem <= 33'(ge ? rem_sh - {1'b0, divisor} : rem_sh);
          quo <= q_nx;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            rem <= '0;
            quo <= '0;
            if (state == DIV_L) begin
              q_l     <= q_nx;
              divisor <= eff_r;
              state   <= DIV_R;
            end else begin
              q_r   <= q_nx;
              state <= DONE;
            end
          end
        end
        default: begin
          note_div_left  <= post(eff_l, q_l);
          note_div_right <= post(eff_r, q_r);
          upd            <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
